// File: rtl/uart_pkg.sv
// Definitions shared by the UART blocks: one-hot state encodings, frame size and the
// default width of the bit-timing counter.
package uart_pkg;

  localparam int DATA_BITS = 8;
  localparam int CNT_W_DEF = 16;
  localparam int ST_W      = 5;

  typedef logic [ST_W-1:0] state_t;

  localparam state_t ST_IDLE  = 5'b00001;
  localparam state_t ST_START = 5'b00010;
  localparam state_t ST_DATA  = 5'b00100;
  localparam state_t ST_STOP  = 5'b01000;
  localparam state_t ST_BREAK = 5'b10000;

endpackage

// File: rtl/uart_rx_if.sv
// Receiver-side UART bundle: serial line and bit period in, received byte and status out.
interface uart_rx_if #(
  parameter int CNT_W = 16
);

  logic             rx_i;
  logic [CNT_W-1:0] baud_div;
  logic [7:0]       rx_data;
  logic             rx_done;
  logic             frame_err;
  logic             rx_busy;

  modport slave (
    input  rx_i,
    input  baud_div,
    output rx_data,
    output rx_done,
    output frame_err,
    output rx_busy
  );

  modport master (
    output rx_i,
    output baud_div,
    input  rx_data,
    input  rx_done,
    input  frame_err,
    input  rx_busy
  );

endinterface

// File: rtl/uart_sync.sv
// Multi-stage synchroniser for an asynchronous, idle-high serial line.
// Reset loads all stages with 1 so that leaving reset never looks like a start bit.
module uart_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sr <= '1;
    end else begin
      sr <= {sr[STAGES-2:0], d};
    end
  end

  assign q = sr[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver. It samples each bit at its centre, using a bit period that is
// captured when the start bit is detected.
//
// state | meaning
// IDLE  | line idle, waiting for a low level
// START | timing to the centre of the start bit, rejecting glitches
// DATA  | sampling eight data bits, LSB first
// STOP  | timing to the centre of the stop bit
// BREAK | stop bit was low; waiting for the line to go high again
module uart_rx
  import uart_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic     clk,
  input  logic     rst,
  uart_rx_if.slave bus
);

  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
  localparam logic [2:0]       LAST_BIT = 3'(DATA_BITS - 1);

  logic                 rx_s;
  state_t               state;
  state_t               state_nxt;
  logic [CNT_W-1:0]     cnt;
  logic [CNT_W-1:0]     bd;
  logic [CNT_W-1:0]     lim;
  logic [2:0]           bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic [DATA_BITS-1:0] data_q;
  logic                 done_q;
  logic                 err_q;
  logic                 tc;
  logic                 cnt_run;
  logic                 bd_load;
  logic                 shift_en;
  logic                 done_set;
  logic                 err_set;

  uart_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (bus.rx_i),
    .q   (rx_s)
  );

  // START runs only half a bit so that every later sample lands mid-bit
  assign lim = (state == ST_START) ? ((bd >> 1) - ONE) : (bd - ONE);
  assign tc  = !(cnt < lim);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (!rx_s) state_nxt = ST_START;
      ST_START: if (tc) state_nxt = rx_s ? ST_IDLE : ST_DATA;
      ST_DATA:  if (tc && (bit_idx == LAST_BIT)) state_nxt = ST_STOP;
      ST_STOP:  if (tc) state_nxt = rx_s ? ST_IDLE : ST_BREAK;
      ST_BREAK: if (rx_s) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    cnt_run  = 1'b0;
    bd_load  = 1'b0;
    shift_en = 1'b0;
    done_set = 1'b0;
    err_set  = 1'b0;
    case (state)
      ST_IDLE:  bd_load = !rx_s;
      ST_START: cnt_run = !tc;
      ST_DATA: begin
        cnt_run  = !tc;
        shift_en = tc;
      end
      ST_STOP: begin
        cnt_run  = !tc;
        done_set = tc && rx_s;
        err_set  = tc && !rx_s;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt     <= '0;
      bd      <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      cnt    <= cnt_run ? (cnt + ONE) : '0;
      done_q <= done_set;
      err_q  <= err_set;
      if (bd_load) bd <= bus.baud_div;
      if (state != ST_DATA) begin
        bit_idx <= '0;
      end else if (shift_en) begin
        bit_idx <= bit_idx + 3'd1;
      end
      if (shift_en) shreg[bit_idx] <= rx_s;
      if (done_set) data_q <= shreg;
    end
  end

  assign bus.rx_data   = data_q;
  assign bus.rx_done   = done_q;
  assign bus.frame_err = err_q;
  assign bus.rx_busy   = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: a behavioural 8N1 transmitter drives the line and a
// scoreboard queue holds the bytes that should come out.
module tb_uart_rx;

  localparam int SYNC = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  int   done_cnt = 0;
  int   err_cnt = 0;
  int   last_start_cyc = 0;
  int   last_done_cyc = 0;
  logic prev_done = 1'b0;
  logic prev_err = 1'b0;
  logic [7:0] exp_q[$];
  int   done_cyc_q[$];

  uart_rx_if #(.CNT_W(16)) bus ();

  uart_rx #(.SYNC_STAGES(SYNC), .CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      if (bus.rx_done || bus.frame_err) begin
        chk("done_err_exclusive", {31'd0, bus.rx_done && bus.frame_err}, 32'd0);
      end
      if (bus.rx_done) begin
        done_cnt++;
        last_done_cyc = cyc;
        done_cyc_q.push_back(cyc);
        chk("done_one_cycle", {31'd0, prev_done}, 32'd0);
        chk("done_expected", {31'd0, exp_q.size() != 0}, 32'd1);
        if (exp_q.size() != 0) chk("rx_data", {24'd0, bus.rx_data}, {24'd0, exp_q.pop_front()});
      end
      if (bus.frame_err) begin
        err_cnt++;
        chk("err_one_cycle", {31'd0, prev_err}, 32'd0);
      end
      prev_done = bus.rx_done;
      prev_err  = bus.frame_err;
    end else begin
      prev_done = 1'b0;
      prev_err  = 1'b0;
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Caller is always aligned to posedge+1, so consecutive calls leave no gap.
  task automatic send_byte(input logic [7:0] d, input logic stop, input int bt, input bit chg);
    logic [9:0] fr;
    fr = {stop, d, 1'b0};
    for (int i = 0; i < 10; i++) begin
      bus.rx_i = fr[i];
      if (i == 0) last_start_cyc = cyc;
      if (chg && i == 4) bus.baud_div = 16'd16;
      idle(bt);
    end
  endtask

  task automatic wait_done(input int n, input int budget);
    int k;
    k = 0;
    while (done_cnt < n && k < budget) begin
      idle(1);
      k++;
    end
    chk("done_count", done_cnt, n);
  endtask

  initial begin
    int d0;
    bus.rx_i     = 1'b1;
    bus.baud_div = 16'd16;
    rst          = 1'b0;
    idle(3);
    chk("rst_rx_data", {24'd0, bus.rx_data}, 32'd0);
    chk("rst_rx_done", {31'd0, bus.rx_done}, 32'd0);
    chk("rst_frame_err", {31'd0, bus.frame_err}, 32'd0);
    chk("rst_rx_busy", {31'd0, bus.rx_busy}, 32'd0);
    rst = 1'b1;
    idle(20);

    // loopback byte and its latency
    exp_q.push_back(8'h4E);
    send_byte(8'h4E, 1'b1, 16, 1'b0);
    wait_done(1, 200);
    chk("latency_bd16", last_done_cyc - last_start_cyc, SYNC + 8 + 9 * 16 + 1);
    chk("no_frame_err", err_cnt, 0);
    idle(32);

    // back-to-back frames with no idle gap
    done_cyc_q.delete();
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'hA5);
    send_byte(8'h00, 1'b1, 16, 1'b0);
    send_byte(8'hFF, 1'b1, 16, 1'b0);
    send_byte(8'hA5, 1'b1, 16, 1'b0);
    wait_done(4, 200);
    chk("b2b_pulses", done_cyc_q.size(), 3);
    if (done_cyc_q.size() == 3) begin
      chk("b2b_space1", done_cyc_q[1] - done_cyc_q[0], 160);
      chk("b2b_space2", done_cyc_q[2] - done_cyc_q[1], 160);
    end
    idle(32);

    // short low glitch must be rejected
    bus.rx_i = 1'b0;
    idle(5);
    bus.rx_i = 1'b1;
    chk("glitch_busy_high", {31'd0, bus.rx_busy}, 32'd1);
    idle(8 + SYNC);
    chk("glitch_busy_low", {31'd0, bus.rx_busy}, 32'd0);
    chk("glitch_no_done", done_cnt, 4);
    chk("glitch_no_err", err_cnt, 0);
    idle(32);

    // framing error followed by a long break
    send_byte(8'h3C, 1'b0, 16, 1'b0);
    bus.rx_i = 1'b0;
    idle(40 * 16);
    chk("break_one_err", err_cnt, 1);
    chk("break_data_kept", {24'd0, bus.rx_data}, 32'h0000_00A5);
    chk("break_no_done", done_cnt, 4);
    bus.rx_i = 1'b1;
    idle(32);
    exp_q.push_back(8'h55);
    send_byte(8'h55, 1'b1, 16, 1'b0);
    wait_done(5, 200);
    idle(32);

    // reset during bit 3 of 8'hC3
    bus.rx_i = 1'b0;
    idle(16);
    bus.rx_i = 1'b1;
    idle(16);
    idle(16);
    bus.rx_i = 1'b0;
    idle(16);
    idle(8);
    chk("mid_busy", {31'd0, bus.rx_busy}, 32'd1);
    rst = 1'b0;
    #1;
    chk("mid_rst_data", {24'd0, bus.rx_data}, 32'd0);
    chk("mid_rst_done", {31'd0, bus.rx_done}, 32'd0);
    chk("mid_rst_err", {31'd0, bus.frame_err}, 32'd0);
    chk("mid_rst_busy", {31'd0, bus.rx_busy}, 32'd0);
    bus.rx_i = 1'b1;
    @(posedge clk);
    #1;
    idle(3);
    rst = 1'b1;
    idle(20);
    chk("mid_no_pulse", done_cnt, 5);
    exp_q.push_back(8'h81);
    send_byte(8'h81, 1'b1, 16, 1'b0);
    wait_done(6, 200);
    idle(32);

    // slow rate, baud_div changed mid-frame
    bus.baud_div = 16'h043D;
    idle(4);
    exp_q.push_back(8'h4E);
    send_byte(8'h4E, 1'b1, 16'h043D, 1'b1);
    wait_done(7, 2000);
    d0 = last_done_cyc - last_start_cyc;
    chk("latency_slow", d0, SYNC + (16'h043D >> 1) + 9 * 16'h043D + 1);
    idle(32);

    chk("queue_empty", exp_q.size(), 0);
    chk("total_frame_err", err_cnt, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
